// File: rtl/nukv_af_sender.sv
// nukv_af_sender: credit-throttled AXI-stream pipeline feeding an almost-full FIFO write port.
// Define NUKV_AF_SENDER_STATS_EN to enable the beat_count statistics counter.
module nukv_af_sender #(
  parameter int DATA_SIZE   = 16,
  parameter int PIPE_STAGES = 3,
  parameter int SLACK       = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 m_axis_talmostfull,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 overflow_err,
  output logic [31:0]          beat_count
);
  // two slots of slack absorb the afull register and the FIFO flag lag
  localparam logic [4:0] MAX_INFLIGHT = 5'(SLACK - 2);
  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic init_cnt_q, init_cnt_d;
  logic afull_q;
  logic [4:0] inflight_q, inflight_d;
  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [PIPE_STAGES:0] vld_sh;
  logic [DATA_SIZE-1:0] dat_q [PIPE_STAGES];
  logic [DATA_SIZE-1:0] dat_d [PIPE_STAGES];
  logic overflow_q, overflow_d;
  logic accept;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = vld_q[PIPE_STAGES-1];
  assign m_axis_tdata  = dat_q[PIPE_STAGES-1];
  assign overflow_err  = overflow_q;
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    s_axis_tready = 1'b0;
    flush_done    = 1'b0;
    unique case (state_q)
      INIT: begin
        init_cnt_d = 1'b1;
        state_d    = init_cnt_q ? RUN : INIT;
      end
      RUN: begin
        s_axis_tready = ~afull_q & (inflight_q < MAX_INFLIGHT) & ~flush_req;
        state_d       = flush_req ? DRAIN : RUN;
      end
      DRAIN: begin
        flush_done = (inflight_q == '0) & ~m_axis_tvalid;
        state_d    = flush_done ? RUN : DRAIN;
      end
      default: state_d = INIT;
    endcase
  end
  // data registers only load behind a valid so tdata holds between beats
  always_comb begin
    vld_sh   = {vld_q, accept};
    vld_d    = vld_sh[PIPE_STAGES-1:0];
    dat_d[0] = accept ? s_axis_tdata : dat_q[0];
    for (int i = 1; i < PIPE_STAGES; i++) dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    inflight_d = inflight_q + 5'(accept) - 5'(m_axis_tvalid);
    overflow_d = overflow_q | (m_axis_tvalid & ~m_axis_tready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= 1'b0;
      afull_q    <= 1'b0;
      inflight_q <= '0;
      vld_q      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < PIPE_STAGES; i++) dat_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      afull_q    <= m_axis_talmostfull;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < PIPE_STAGES; i++) dat_q[i] <= dat_d[i];
    end
  end
`ifdef NUKV_AF_SENDER_STATS_EN
  logic [31:0] beat_q, beat_d;
  assign beat_d     = flush_done ? '0 : beat_q + 32'(m_axis_tvalid);
  assign beat_count = beat_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else beat_q <= beat_d;
  end
`else
  assign beat_count = '0;
`endif
endmodule

// File: doc/nukv_af_sender.md
Name: nukv_af_sender

Overview:
- Transmit-side companion for the almost-full-throttled FIFO write port used throughout nukv.
- Takes an upstream AXI-stream with tvalid/tready and forwards beats through a fixed-depth register pipeline. The pipeline feeds a FIFO write port that exposes only almostfull plus a late tready.
- Guarantees the FIFO never sees a write it cannot absorb. Supports an explicit flush/drain handshake.

Parameters:
- DATA_SIZE, 16, data width in bits.
- PIPE_STAGES, 3, register stages between accept and FIFO write; legal 1..16.
- SLACK, 7, free FIFO entries left when downstream almostfull asserts; must satisfy SLACK >= 3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_SIZE  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- m_axis_tdata  out  DATA_SIZE  FIFO write data.
- m_axis_tvalid  out  1  FIFO write enable.
- m_axis_tready  in  1  FIFO ready, for overflow detection only; never stalls the pipeline.
- m_axis_talmostfull  in  1  FIFO almost-full.
- flush_req  in  1  level; request drain.
- flush_done  out  1  one-cycle pulse when drain completes.
- overflow_err  out  1  sticky: a beat was written while the FIFO was not ready.
- beat_count  out  32  beats emitted (see Optional Feature).

Behaviour:
- Reset (rst_n low, async):
  - all pipeline valids, s_axis_tready, m_axis_tvalid, flush_done, overflow_err and beat_count are 0.
  - m_axis_tdata is 0.
  - inflight counter is 0; FSM goes to INIT.
- Reset mid-operation discards all in-flight beats; no partial output.
- afull_q is m_axis_talmostfull registered once.
- MAX_INFLIGHT = SLACK-2 (covers the afull register plus the FIFO flag lag).
- FSM:
  - INIT: count 2 cycles after reset release, then go to RUN. s_axis_tready is 0 in INIT.
  - RUN: s_axis_tready = ~afull_q & (inflight < MAX_INFLIGHT) & ~flush_req. On flush_req=1, go to DRAIN.
  - DRAIN: s_axis_tready = 0; the pipeline keeps shifting. When inflight == 0 and no beat is emitted that cycle, pulse flush_done for 1 cycle and go to RUN. If flush_req is still high at that point, re-enter DRAIN next cycle (one pulse per entry).
- Accept = s_axis_tvalid & s_axis_tready. The beat enters stage 0 on that edge.
- Pipeline:
  - shifts every cycle unconditionally.
  - an accepted beat appears on m_axis_tvalid/tdata exactly PIPE_STAGES cycles after the accept edge, as a single-cycle strobe.
  - back-to-back accepts give back-to-back writes; order is preserved.
- Inflight counter: 5 bits; +1 on accept, -1 on emit, unchanged on simultaneous accept+emit. It never exceeds MAX_INFLIGHT and never underflows.
- Throttle boundary:
  - afull rising at cycle t → s_axis_tready is 0 from t+1.
  - at most MAX_INFLIGHT further writes follow.
  - afull falling → ready returns 1 cycle later, if credit allows.
- overflow_err: set on any cycle with m_axis_tvalid & ~m_axis_tready. Cleared only by reset. The beat is still presented; no retry.
- tdata on non-valid cycles holds its last value. Verification checks tdata only when tvalid=1.

Optional Feature:
- Macro NUKV_AF_SENDER_STATS_EN.
- Defined: beat_count increments by 1 on every m_axis_tvalid cycle and wraps 0xFFFFFFFF→0. It is cleared on reset and on the flush_done pulse cycle, where the clear has priority over the increment.
- Undefined: beat_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset/INIT: release rst_n with s_axis_tvalid=1 → s_axis_tready=0 for 2 cycles, then 1. The first accepted beat 0x0001 appears on m_axis 3 cycles after the accept edge.
- Streaming: 20 back-to-back beats 0x0000..0x0013 with afull=0 → 20 consecutive m_axis_tvalid cycles, same order, latency 3, inflight peaks at 3.
- Throttle: hold afull=1 from cycle 10 of a continuous stream → ready falls at cycle 11. Writes after cycle 10 are ≤5. afull=0 at cycle 30 → ready=1 at cycle 31.
- Async reset mid-stream: assert rst_n=0 while 3 beats are in flight → m_axis_tvalid=0 immediately and no stale beat after release. With STATS_EN, beat_count=0.
- Flush: flush_req=1 while 3 beats are in flight → ready=0. The 3 beats emit, then flush_done pulses once, 1 cycle after the last write. With STATS_EN, beat_count reads 0 the following cycle.
- Overflow: force m_axis_tready=0 during one emitted beat → overflow_err=1 and stays 1 through 100 cycles of normal traffic until reset.
